// File: rtl/serial_pattern_gen.sv
// Serial MSB-first pattern transmitter with start/busy/done handshake.
// Optional even-parity trailer bit enabled by defining SERIAL_PATTERN_GEN_PARITY_EN.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for start with nonzero len; outputs quiet
// SHIFT  | one pattern bit per cycle on Out, counter counts down
// PARITY | even-parity bit of the frame on Out (parity build only)
// DONE   | one-cycle done pulse, start ignored
module serial_pattern_gen #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   output logic             Out,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

   state_t           state, state_next;
   logic [WIDTH-1:0] shreg, shreg_next;
   logic [LEN_W-1:0] cnt, cnt_next;
   logic [LEN_W-1:0] n_clamp;
   logic [WIDTH-1:0] aligned;
   logic             out_next, valid_next, busy_next, done_next;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
   logic             par, par_next;
`endif

   // Left-justify the frame so the next bit to send is always the register MSB.
   assign n_clamp = (len > WIDTH_L) ? WIDTH_L : len;
   assign aligned = pattern << (WIDTH_L - n_clamp);

   always_comb begin
      state_next = state;
      shreg_next = shreg;
      cnt_next   = cnt;
      out_next   = 1'b0;
      valid_next = 1'b0;
      busy_next  = 1'b1;
      done_next  = 1'b0;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
      par_next   = par;
`endif
      case (state)
         IDLE: begin
            busy_next = 1'b0;
            if (start && (len != '0)) begin
               state_next = SHIFT;
               shreg_next = aligned;
               cnt_next   = n_clamp;
               out_next   = aligned[WIDTH-1];
               valid_next = 1'b1;
               busy_next  = 1'b1;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
               par_next   = ^aligned;
`endif
            end
         end
         SHIFT: begin
            cnt_next   = cnt - LEN_W'(1);
            shreg_next = shreg << 1;
            if (cnt == LEN_W'(1)) begin
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
               state_next = PARITY;
               out_next   = par;
               valid_next = 1'b1;
`else
               state_next = DONE;
               done_next  = 1'b1;
`endif
            end else begin
               out_next   = shreg[WIDTH-2];
               valid_next = 1'b1;
            end
         end
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
         PARITY: begin
            state_next = DONE;
            done_next  = 1'b1;
         end
`endif
         DONE: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
         Out   <= 1'b0;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_next;
         shreg <= shreg_next;
         cnt   <= cnt_next;
         Out   <= out_next;
         valid <= valid_next;
         busy  <= busy_next;
         done  <= done_next;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
         par   <= par_next;
`endif
      end
   end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed self-checking bench for serial_pattern_gen (default and parity builds).
module tb_serial_pattern_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] pattern;
   logic [3:0] len;
   logic       Out, valid, busy, done;

   int tests = 0;
   int fails = 0;

   serial_pattern_gen #(.WIDTH(8), .LEN_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .pattern (pattern),
      .len     (len),
      .Out     (Out),
      .valid   (valid),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".out"},   Out,   1'b0);
      chk({tag, ".valid"}, valid, 1'b0);
      chk({tag, ".busy"},  busy,  1'b0);
      chk({tag, ".done"},  done,  1'b0);
   endtask

   // Entered just after edge 0; leaves just after edge n.
   task automatic check_frame(input string tag, input logic [7:0] bits, input int n);
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s.bit%0d", tag, k), Out, bits[n-1-k]);
         chk($sformatf("%s.valid%0d", tag, k), valid, 1'b1);
         chk($sformatf("%s.busy%0d", tag, k), busy, 1'b1);
         chk($sformatf("%s.done%0d", tag, k), done, 1'b0);
         tick();
      end
   endtask

   task automatic check_parity(input string tag, input logic exp_par);
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
      chk({tag, ".par"},       Out,   exp_par);
      chk({tag, ".par_valid"}, valid, 1'b1);
      chk({tag, ".par_busy"},  busy,  1'b1);
      tick();
`else
      chk({tag, ".no_par_done"}, done, 1'b1 ^ (exp_par & 1'b0));
`endif
   endtask

   // Entered in the DONE cycle; leaves just after the following IDLE edge.
   task automatic check_done(input string tag);
      chk({tag, ".done"},       done,  1'b1);
      chk({tag, ".done_out"},   Out,   1'b0);
      chk({tag, ".done_valid"}, valid, 1'b0);
      chk({tag, ".done_busy"},  busy,  1'b1);
      tick();
      chk_quiet({tag, ".idle"});
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      pattern = 8'h00;
      len     = 4'd0;
      #1;
      chk_quiet("reset");
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk_quiet("post_reset");

      // reset mid-frame
      pattern = 8'h1B; len = 4'd5; start = 1'b1;
      tick();
      start = 1'b0;
      chk("rst_mid.bit0", Out, 1'b1);
      chk("rst_mid.valid0", valid, 1'b1);
      tick();
      chk("rst_mid.bit1", Out, 1'b1);
      reset = 1'b1;
      #1;
      chk_quiet("rst_mid.async");
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("rst_mid.after%0d.valid", i), valid, 1'b0);
         chk($sformatf("rst_mid.after%0d.done", i), done, 1'b0);
         tick();
      end

      // basic frame 0001_1011, len 5
      pattern = 8'b0001_1011; len = 4'd5; start = 1'b1;
      tick();
      start = 1'b0;
      check_frame("basic", 8'b0001_1011, 5);
      check_parity("basic", 1'b0);
      check_done("basic");

      // len 4 of same pattern: bits 1,0,1,1
      pattern = 8'h1B; len = 4'd4; start = 1'b1;
      tick();
      start = 1'b0;
      check_frame("len4", 8'b0000_1011, 4);
      check_parity("len4", 1'b1);
      check_done("len4");

      // clamp: len 12 sends all 8 bits
      pattern = 8'hA5; len = 4'd12; start = 1'b1;
      tick();
      start = 1'b0;
      pattern = 8'hFF;
      check_frame("clamp", 8'b1010_0101, 8);
      check_parity("clamp", 1'b0);
      check_done("clamp");

      // len 0 with start held: nothing happens
      pattern = 8'hFF; len = 4'd0; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_quiet($sformatf("len0.%0d", i));
      end

      // back-to-back with start held high
      pattern = 8'h03; len = 4'd2; start = 1'b1;
      tick();
      check_frame("b2b1", 8'b0000_0011, 2);
      check_parity("b2b1", 1'b0);
      check_done("b2b1");
      tick();
      pattern = 8'h02;
      check_frame("b2b2", 8'b0000_0011, 2);
      check_parity("b2b2", 1'b0);
      check_done("b2b2");
      tick();
      start = 1'b0;
      check_frame("b2b3", 8'b0000_0010, 2);
      check_parity("b2b3", 1'b1);
      check_done("b2b3");
      tick();
      chk_quiet("end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
